// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the requester-to-FIFO arbiter and its pop-side FSM.
// Pure declarations: no logic, no latency, no backpressure of its own.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_WAIT = 2'd1,
    P_HOLD = 2'd2
  } pop_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_N_REQ     = 2;
  localparam int DEF_BURST_MAX = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or above ptr, wrapping modulo N_REQ.
// Zero latency; no backpressure -- grant_vld is low when no request is active.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_vld
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]   off;
  logic [PTR_W:0]     sum;

  // Rotating through a doubled vector puts the pointer's requester at bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_REQ];

  always_comb begin
    off       = '0;
    grant_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off       = PTR_W'(i);
        grant_vld = 1'b1;
      end
    end
  end

  assign sum       = {1'b0, ptr} + {1'b0, off};
  assign grant_idx = (sum >= N_EXT) ? PTR_W'(sum - N_EXT) : sum[PTR_W-1:0];
  assign grant     = grant_vld ? (N_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin merge of N_REQ requesters into a FIFO (push side combinational), plus a pop FSM feeding tx (pop->tx_valid 2 cycles, one word per 3 cycles).
// Backpressure: fifo_full drops every req_ready; tx_valid/tx_data hold until tx_ready. Define FIFO_ARB_BURST_EN for up to BURST_MAX back-to-back grants.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_REQ     = DEF_N_REQ,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_push_data,
  output logic                     fifo_pop,
  input  logic [WIDTH-1:0]         fifo_pop_data,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [WIDTH-1:0]         tx_data,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d, win_idx, win_inc;
  logic [N_REQ-1:0] win_onehot;
  logic             win_vld;
  logic             xfer;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .grant_vld (win_vld)
  );

  assign grant_id  = ptr_q;
  assign xfer      = win_vld && !fifo_full && !reset;
  assign req_ready = xfer ? win_onehot : '0;
  assign fifo_push = xfer;
  assign win_inc   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  always_comb begin
    fifo_push_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_onehot[k]) fifo_push_data = req_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  logic [CNT_W-1:0] burst_q, burst_d, burst_base;

  // A grant to someone other than the pointer starts a fresh burst on that requester.
  always_comb begin
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    burst_base = (win_idx == ptr_q) ? burst_q : '0;
    if (xfer) begin
      if (burst_base < CNT_W'(BURST_MAX - 1)) begin
        ptr_d   = win_idx;
        burst_d = burst_base + CNT_W'(1);
      end else begin
        ptr_d   = win_inc;
        burst_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) burst_q <= '0;
    else       burst_q <= burst_d;
  end
`else
  logic burst_cfg_unused;
  assign burst_cfg_unused = (BURST_MAX > 0);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = win_inc;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  pop_state_t state_q, state_d;
  logic       load_tx, clr_tx;

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load_tx  = 1'b0;
    clr_tx   = 1'b0;
    case (state_q)
      P_IDLE: begin
        if (!fifo_empty && !reset) begin
          fifo_pop = 1'b1;
          state_d  = P_WAIT;
        end
      end
      P_WAIT: begin
        load_tx = 1'b1;
        state_d = P_HOLD;
      end
      P_HOLD: begin
        if (tx_ready) begin
          clr_tx  = 1'b1;
          state_d = P_IDLE;
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  // Reset drops any word in flight; it is never replayed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= P_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state_q <= state_d;
      if (load_tx) begin
        tx_data  <= fifo_pop_data;
        tx_valid <= 1'b1;
      end else if (clr_tx) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule
